// File: rtl/deskew_buffer_1d_pkg.sv
// Shared types and sizing helpers for the lane deskew buffer.
// Depth and counter width are derived here so every file agrees.
package deskew_buffer_1d_pkg;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_PRECISION = 4;

    typedef logic [DEF_PRECISION-1:0] lane_vec_t [DEF_N];

    function automatic int unsigned cnt_width(
        input int unsigned frame_len
    );
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    function automatic int unsigned lane_depth(
        input int unsigned n,
        input int unsigned i,
        input int unsigned delay
    );
        return (n - 1 - i) + delay;
    endfunction

endpackage

// File: rtl/deskew_buffer_1d_if.sv
// Skewed-in / aligned-out bundle of the deskew buffer.
// The producer side drives en, ivalid and idata.
interface deskew_buffer_1d_if
    import deskew_buffer_1d_pkg::*;
#(
    parameter int N         = 4,
    parameter int PRECISION = 4
);
    logic                 en;
    logic [N-1:0]         ivalid;
    logic [PRECISION-1:0] idata [N];
    logic [PRECISION-1:0] odata [N];
    logic                 ovalid;
    logic                 olast;
    logic                 oerr;

    modport master (
        output en, ivalid, idata,
        input  odata, ovalid, olast, oerr
    );

    modport slave (
        input  en, ivalid, idata,
        output odata, ovalid, olast, oerr
    );
endinterface

// File: rtl/deskew_buffer_1d_lane_delay.sv
// Per-lane shift register with enable and synchronous clear.
// Zero depth degenerates to a wire.
module deskew_lane_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, en};
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];

        // shift one stage per enabled edge
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++)
                    sr[k] <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int k = 1; k < DEPTH; k++)
                    sr[k] <= sr[k-1];
            end
        end

        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/deskew_buffer_1d.sv
// Triangular-skew remover: delays lanes, aligns,
// counts frames and latches misalignment.
module deskew_buffer_1d
    import deskew_buffer_1d_pkg::*;
#(
    parameter int N         = 4,
    parameter int PRECISION = 4,
    parameter int DELAY     = 0,
    parameter int FRAME_LEN = 8
) (
    input logic               clk,
    input logic               rst,
    deskew_buffer_1d_if.slave bus
);
    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);

    logic [N-1:0]         dv;
    logic [PRECISION-1:0] dd [N];
    logic [CW-1:0]        cnt;
    logic [PRECISION-1:0] odata_q [N];
    logic                 ovalid_q;
    logic                 olast_q;
    logic                 oerr_q;
    logic                 all_v;
    logic                 no_v;
    logic                 part_v;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [PRECISION:0] q;

        deskew_lane_delay #(
            .DEPTH(lane_depth(N, i, DELAY)),
            .WIDTH(PRECISION + 1)
        ) u_delay (
            .clk(clk),
            .rst(rst),
            .en (bus.en),
            .d  ({bus.ivalid[i], bus.idata[i]}),
            .q  (q)
        );

        assign dv[i] = q[PRECISION];
        assign dd[i] = q[PRECISION-1:0];
    end

    // classify the delayed valids as full, empty or partial
    always_comb begin
        all_v  = &dv;
        no_v   = ~|dv;
        part_v = ~all_v & ~no_v;
    end

    // align stage: emit full vectors, count frames, latch errors
    always_ff @(posedge clk) begin
        if (rst) begin
            foreach (odata_q[i])
                odata_q[i] <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            oerr_q   <= 1'b0;
            cnt      <= '0;
        end else if (bus.en) begin
            unique case (1'b1)
                all_v: begin
                    odata_q  <= dd;
                    ovalid_q <= 1'b1;
                    olast_q  <= (cnt == CNT_MAX);
                    cnt      <= (cnt == CNT_MAX)
                              ? '0 : cnt + CW'(1);
                end
                no_v: begin
                    ovalid_q <= 1'b0;
                    olast_q  <= 1'b0;
                end
                part_v: begin
                    ovalid_q <= 1'b0;
                    olast_q  <= 1'b0;
                    oerr_q   <= 1'b1;
                end
            endcase
        end else begin
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.olast  = olast_q;
    assign bus.oerr   = oerr_q;
endmodule

// File: tb/tb_deskew_buffer_1d.sv
// Bench for deskew_buffer_1d: directed scenarios plus random
// traffic against a history-based reference model (DELAY 0 and 2).
module tb_deskew_buffer_1d;
    import deskew_buffer_1d_pkg::*;

    localparam int FL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    deskew_buffer_1d_if #(.N(4), .PRECISION(4)) b0 ();
    deskew_buffer_1d_if #(.N(4), .PRECISION(4)) b1 ();

    assign b1.en     = b0.en;
    assign b1.ivalid = b0.ivalid;
    assign b1.idata  = b0.idata;

    deskew_buffer_1d #(
        .N(4), .PRECISION(4), .DELAY(0), .FRAME_LEN(FL)
    ) dut0 (.clk(clk), .rst(rst), .bus(b0));

    deskew_buffer_1d #(
        .N(4), .PRECISION(4), .DELAY(2), .FRAME_LEN(FL)
    ) dut1 (.clk(clk), .rst(rst), .bus(b1));

    function automatic logic [15:0] pk(input lane_vec_t v);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // reference model: history of accepted inputs since reset
    logic [3:0] hv [$];
    lane_vec_t  hd [$];
    lane_vec_t  m_od [2];
    logic       m_ov [2];
    logic       m_ol [2];
    logic       m_er [2];
    int         m_cnt [2];
    int         mdly, mnv, midx;
    lane_vec_t  mv;

    always @(posedge clk) begin
        if (rst) begin
            hv.delete();
            hd.delete();
            for (int m = 0; m < 2; m++) begin
                m_od[m] = '{default: 4'h0};
                m_ov[m] = 0; m_ol[m] = 0;
                m_er[m] = 0; m_cnt[m] = 0;
            end
        end else if (b0.en) begin
            hv.push_back(b0.ivalid);
            hd.push_back(b0.idata);
            for (int m = 0; m < 2; m++) begin
                mdly = (m == 0) ? 0 : 2;
                mnv = 0;
                for (int i = 0; i < 4; i++) begin
                    midx = hv.size() - 1 - (3 - i + mdly);
                    mv[i] = 4'h0;
                    if (midx >= 0 && hv[midx][i]) begin
                        mnv++;
                        mv[i] = hd[midx][i];
                    end
                end
                m_ov[m] = (mnv == 4);
                m_ol[m] = (mnv == 4) && (m_cnt[m] == FL - 1);
                if (mnv == 4) begin
                    m_od[m] = mv;
                    m_cnt[m] = (m_cnt[m] + 1) % FL;
                end else if (mnv != 0) begin
                    m_er[m] = 1;
                end
            end
        end else begin
            m_ov[0] = 0; m_ol[0] = 0;
            m_ov[1] = 0; m_ol[1] = 0;
        end
    end

    // schedule indexed by enabled cycle; observations by wall cycle
    logic [3:0]  s_v [64];
    lane_vec_t   s_d [64];
    logic        o_ov [2][81];
    logic        o_ol [2][81];
    logic        o_er [2][81];
    logic [15:0] o_od [2][81];

    task automatic clr_sched();
        for (int e = 0; e < 64; e++) begin
            s_v[e] = 4'h0;
            for (int i = 0; i < 4; i++)
                s_d[e][i] = 4'($urandom);
        end
    endtask

    task automatic put_lane(input int c, input int l,
                            input logic [3:0] val);
        s_v[c][l] = 1'b1;
        s_d[c][l] = val;
    endtask

    task automatic put_vec(input int c, input int base);
        for (int i = 0; i < 4; i++)
            put_lane(c + i, i, 4'(base + i));
    endtask

    task automatic play(input int ncyc,
                        input logic [79:0] stall,
                        input logic [79:0] rstm);
        int e = 0;
        bit idle = 0;
        for (int w = 0; w < ncyc; w++) begin
            b0.en = !stall[w];
            rst = rstm[w];
            if (!stall[w] && !rstm[w] && !idle && e < 64) begin
                b0.ivalid = s_v[e];
                b0.idata = s_d[e];
                e++;
            end else begin
                b0.ivalid = idle ? 4'h0 : 4'($urandom);
                for (int i = 0; i < 4; i++)
                    b0.idata[i] = 4'($urandom);
            end
            if (rstm[w]) idle = 1;
            @(negedge clk);
            o_ov[0][w+1] = b0.ovalid; o_ov[1][w+1] = b1.ovalid;
            o_ol[0][w+1] = b0.olast;  o_ol[1][w+1] = b1.olast;
            o_er[0][w+1] = b0.oerr;   o_er[1][w+1] = b1.oerr;
            o_od[0][w+1] = pk(b0.odata);
            o_od[1][w+1] = pk(b1.odata);
        end
        rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b0.en = 1'b1;
        b0.ivalid = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            b0.en = 1'($urandom);
            b0.ivalid = 4'($urandom);
            for (int i = 0; i < 4; i++)
                b0.idata[i] = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        b0.en = 1'b1;
        b0.ivalid = 4'h0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            logic [15:0] od;
            logic ov, ol, er;
            od = (m == 0) ? pk(b0.odata) : pk(b1.odata);
            ov = (m == 0) ? b0.ovalid : b1.ovalid;
            ol = (m == 0) ? b0.olast : b1.olast;
            er = (m == 0) ? b0.oerr : b1.oerr;
            checks += 4;
            if (od !== 16'h0) begin
                failures++;
                $display("FAIL reset_odata dut%0d got=%h exp=0000",
                         m, od);
            end
            if (ov !== 1'b0) begin
                failures++;
                $display("FAIL reset_ovalid dut%0d got=%b exp=0", m, ov);
            end
            if (ol !== 1'b0) begin
                failures++;
                $display("FAIL reset_olast dut%0d got=%b exp=0", m, ol);
            end
            if (er !== 1'b0) begin
                failures++;
                $display("FAIL reset_oerr dut%0d got=%b exp=0", m, er);
            end
        end
    endtask

    task automatic test_single();
        lane_vec_t ex;
        ex = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        clr_sched();
        put_vec(0, 1);
        play(12, '0, '0);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (o_ov[0][c] !== (c == 4)) begin
                failures++;
                $display("FAIL single_ovalid c=%0d got=%b exp=%b",
                         c, o_ov[0][c], (c == 4));
            end
        end
        checks += 3;
        if (o_od[0][4] !== pk(ex)) begin
            failures++;
            $display("FAIL single_odata got=%h exp=%h",
                     o_od[0][4], pk(ex));
        end
        if (o_ol[0][4] !== 1'b0) begin
            failures++;
            $display("FAIL single_olast got=%b exp=0", o_ol[0][4]);
        end
        if (o_er[0][12] !== 1'b0) begin
            failures++;
            $display("FAIL single_oerr got=%b exp=0", o_er[0][12]);
        end
    endtask

    task automatic test_frame();
        lane_vec_t ex;
        do_reset();
        clr_sched();
        for (int k = 0; k < 4; k++) put_vec(k, 4 * k + 1);
        play(14, '0, '0);
        for (int c = 1; c <= 14; c++) begin
            checks += 2;
            if (o_ov[0][c] !== (c >= 4 && c <= 7)) begin
                failures++;
                $display("FAIL frame_ovalid c=%0d got=%b", c, o_ov[0][c]);
            end
            if (o_ol[0][c] !== (c == 6)) begin
                failures++;
                $display("FAIL frame_olast c=%0d got=%b exp=%b",
                         c, o_ol[0][c], (c == 6));
            end
            if (c >= 4 && c <= 7) begin
                for (int i = 0; i < 4; i++)
                    ex[i] = 4'(4 * (c - 4) + 1 + i);
                checks++;
                if (o_od[0][c] !== pk(ex)) begin
                    failures++;
                    $display("FAIL frame_odata c=%0d got=%h exp=%h",
                             c, o_od[0][c], pk(ex));
                end
            end
        end
    endtask

    task automatic test_stall();
        lane_vec_t ex;
        int pulses = 0;
        do_reset();
        clr_sched();
        for (int k = 0; k < 3; k++) put_vec(k, 4 * k + 1);
        play(14, 80'h18, '0);
        for (int c = 1; c <= 14; c++) begin
            pulses += int'(o_ov[0][c] === 1'b1);
            checks += 2;
            if (o_ov[0][c] !== (c >= 6 && c <= 8)) begin
                failures++;
                $display("FAIL stall_ovalid c=%0d got=%b", c, o_ov[0][c]);
            end
            if (o_ol[0][c] !== (c == 8)) begin
                failures++;
                $display("FAIL stall_olast c=%0d got=%b", c, o_ol[0][c]);
            end
            if (c >= 6 && c <= 8) begin
                for (int i = 0; i < 4; i++)
                    ex[i] = 4'(4 * (c - 6) + 1 + i);
                checks++;
                if (o_od[0][c] !== pk(ex)) begin
                    failures++;
                    $display("FAIL stall_odata c=%0d got=%h exp=%h",
                             c, o_od[0][c], pk(ex));
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL stall_pulses got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        clr_sched();
        put_lane(0, 0, 4'd1);
        put_lane(1, 1, 4'd2);
        put_lane(3, 2, 4'd3);
        put_lane(3, 3, 4'd4);
        play(25, '0, '0);
        for (int c = 1; c <= 25; c++) begin
            checks += 2;
            if (o_ov[0][c] !== 1'b0) begin
                failures++;
                $display("FAIL misalign_ovalid c=%0d got=%b exp=0",
                         c, o_ov[0][c]);
            end
            if (o_er[0][c] !== (c >= 4)) begin
                failures++;
                $display("FAIL misalign_oerr c=%0d got=%b exp=%b",
                         c, o_er[0][c], (c >= 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        lane_vec_t ex;
        ex = '{4'd7, 4'd8, 4'd9, 4'd10};
        do_reset();
        clr_sched();
        put_vec(0, 1);
        put_vec(1, 5);
        play(10, '0, '0);
        clr_sched();
        for (int k = 0; k < 4; k++) put_vec(k, 4 * k + 1);
        play(16, '0, 80'h8);
        for (int c = 1; c <= 16; c++) begin
            for (int m = 0; m < 2; m++) begin
                checks += 2;
                if (o_ov[m][c] !== 1'b0) begin
                    failures++;
                    $display("FAIL midrst_ovalid dut%0d c=%0d got=%b",
                             m, c, o_ov[m][c]);
                end
                if (o_er[m][c] !== 1'b0) begin
                    failures++;
                    $display("FAIL midrst_oerr dut%0d c=%0d got=%b",
                             m, c, o_er[m][c]);
                end
            end
        end
        clr_sched();
        put_vec(0, 7);
        play(12, '0, '0);
        for (int c = 1; c <= 12; c++) begin
            for (int m = 0; m < 2; m++) begin
                int lat;
                lat = (m == 0) ? 4 : 6;
                checks++;
                if (o_ov[m][c] !== (c == lat)) begin
                    failures++;
                    $display("FAIL fresh_ovalid dut%0d c=%0d got=%b",
                             m, c, o_ov[m][c]);
                end
                if (c == lat) begin
                    checks += 2;
                    if (o_od[m][c] !== pk(ex)) begin
                        failures++;
                        $display("FAIL fresh_odata dut%0d got=%h exp=%h",
                                 m, o_od[m][c], pk(ex));
                    end
                    if (o_ol[m][c] !== 1'b0) begin
                        failures++;
                        $display("FAIL fresh_olast dut%0d got=%b exp=0",
                                 m, o_ol[m][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] sh = 4'h0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            b0.en = ($urandom_range(0, 4) != 0);
            if (rst) begin
                sh = 4'h0;
                b0.ivalid = 4'($urandom);
            end else if (b0.en) begin
                sh = {sh[2:0], ($urandom_range(0, 3) != 0)};
                b0.ivalid = sh;
                if ($urandom_range(0, 29) == 0)
                    b0.ivalid[$urandom_range(0, 3)] ^= 1'b1;
            end else begin
                b0.ivalid = 4'($urandom);
            end
            for (int i = 0; i < 4; i++)
                b0.idata[i] = 4'($urandom);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic [15:0] od;
                logic ov, ol, er;
                od = (m == 0) ? pk(b0.odata) : pk(b1.odata);
                ov = (m == 0) ? b0.ovalid : b1.ovalid;
                ol = (m == 0) ? b0.olast : b1.olast;
                er = (m == 0) ? b0.oerr : b1.oerr;
                checks++;
                if (ov !== m_ov[m] || ol !== m_ol[m] ||
                    er !== m_er[m] || od !== pk(m_od[m])) begin
                    failures++;
                    $display("FAIL random dut%0d n=%0d got=%b%b%b/%h exp=%b%b%b/%h",
                             m, n, ov, ol, er, od,
                             m_ov[m], m_ol[m], m_er[m], pk(m_od[m]));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        b0.en = 1'b0;
        b0.ivalid = 4'h0;
        for (int i = 0; i < 4; i++) b0.idata[i] = 4'h0;
        test_reset();
        test_single();
        test_frame();
        test_stall();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
